// File: rtl/main_memory_ctrl_if.sv
// Cache-to-memory block handshake: request channel plus held-valid refill response.
// The cache side drives the master modport and the memory side drives the slave modport.
interface main_memory_ctrl_if #(
    parameter int ADDR_WIDTH  = 26,
    parameter int BLOCK_WIDTH = 128
);
    logic                   req_valid_mem;
    logic                   req_ready_mem;
    logic                   read_en_mem;
    logic                   write_en_mem;
    logic [ADDR_WIDTH-1:0]  addr_mem;
    logic [BLOCK_WIDTH-1:0] wdata_mem;
    logic                   resp_valid_mem;
    logic                   resp_ready_mem;
    logic [BLOCK_WIDTH-1:0] rdata_mem;

    modport master (
        output req_valid_mem, read_en_mem, write_en_mem, addr_mem, wdata_mem, resp_ready_mem,
        input  req_ready_mem, resp_valid_mem, rdata_mem
    );

    modport slave (
        input  req_valid_mem, read_en_mem, write_en_mem, addr_mem, wdata_mem, resp_ready_mem,
        output req_ready_mem, resp_valid_mem, rdata_mem
    );
endinterface

// File: rtl/main_memory_ctrl.sv
// Block-granular main memory behind the cache. It serves one request at a time, applies
// the configured read and write latencies, and keeps saturating counters of completed reads and writes.
module main_memory_ctrl #(
    parameter int BLOCK_WIDTH   = 128,
    parameter int ADDR_WIDTH    = 26,
    parameter int MEM_DEPTH     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    main_memory_ctrl_if.slave    bus,
    output logic                 protocol_err,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count
);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int WR_LOAD = (WRITE_LATENCY > 0) ? WRITE_LATENCY - 1 : 0;
    localparam int RD_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_WAIT, RD_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [BLOCK_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [BLOCK_WIDTH-1:0] r_rdata;
    logic                   r_perr;
    logic [15:0]            r_rd_count;
    logic [15:0]            r_wr_count;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_illegal;
    logic                   w_resp_take;
    logic [IDX_W-1:0]       w_idx;

    assign w_ready     = (r_state == IDLE) && !rst;
    assign w_accept    = bus.req_valid_mem && w_ready;
    assign w_wr_acc    = w_accept && bus.write_en_mem && !bus.read_en_mem;
    assign w_rd_acc    = w_accept && bus.read_en_mem && !bus.write_en_mem;
    assign w_illegal   = w_accept && (bus.read_en_mem == bus.write_en_mem);
    assign w_resp_take = (r_state == RD_RESP) && bus.resp_ready_mem;
    assign w_idx       = bus.addr_mem[IDX_W-1:0];

    // Only the low index bits address the array; the upper block-address bits are dropped.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_upper_addr
            logic w_unused_upper;
            assign w_unused_upper = ^bus.addr_mem[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_acc)
                    w_next = (WRITE_LATENCY == 0) ? IDLE : WR_BUSY;
                else if (w_rd_acc)
                    w_next = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
            end
            WR_BUSY: if (r_cnt == '0) w_next = IDLE;
            RD_WAIT: if (r_cnt == '0) w_next = RD_RESP;
            RD_RESP: if (bus.resp_ready_mem) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_perr     <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_next;
            r_perr  <= w_illegal;
            if (w_wr_acc)
                r_cnt <= CNT_W'(WR_LOAD);
            else if (w_rd_acc)
                r_cnt <= CNT_W'(RD_LOAD);
            else if ((r_state == WR_BUSY || r_state == RD_WAIT) && r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
            // The refill block is captured at accept, so a later write cannot change it.
            if (w_rd_acc)
                r_rdata <= r_mem[w_idx];
            if (w_wr_acc && r_wr_count != 16'hFFFF)
                r_wr_count <= r_wr_count + 16'd1;
            if (w_resp_take && r_rd_count != 16'hFFFF)
                r_rd_count <= r_rd_count + 16'd1;
        end
    end

    // The array is not reset; a write is committed at its accept edge.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[w_idx] <= bus.wdata_mem;
    end

    assign bus.req_ready_mem  = w_ready;
    assign bus.resp_valid_mem = (r_state == RD_RESP);
    assign bus.rdata_mem      = r_rdata;
    assign protocol_err       = r_perr;
    assign read_count         = r_rd_count;
    assign write_count        = r_wr_count;
endmodule
